// File: rtl/vec_inst_issue.sv
// Scalar-to-vector instruction issue unit: in-order {inst, rs1, rs2} FIFO toward the vector
// side, plus vl writeback to the scalar register file for vsetvl/vsetvli/vsetivli.
//
// state   | meaning
// IDLE    | FIFO empty, nothing in flight
// ISSUE   | FIFO holds entries, head offered to the vector side
// WAIT_VL | config instruction issued, waiting for the vector CSR to report vl
// WB      | one-cycle vl writeback to the scalar register file
module vec_inst_issue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            scalar_inst_valid,
    input  logic [XLEN-1:0] scalar_inst,
    input  logic [XLEN-1:0] scalar_rs1_data,
    input  logic [XLEN-1:0] scalar_rs2_data,
    output logic            scalar_inst_ready,
    output logic            scalar_rd_valid,
    output logic [4:0]      scalar_rd_addr,
    output logic [XLEN-1:0] scalar_rd_data,
    output logic            illegal_inst,
    output logic            vec_inst_valid,
    input  logic            vec_inst_ready,
    output logic [XLEN-1:0] vec_inst,
    output logic [XLEN-1:0] vec_rs1_data,
    output logic [XLEN-1:0] vec_rs2_data,
    input  logic            vec_vl_valid,
    input  logic [XLEN-1:0] vec_vl,
    output logic            busy
);
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);
    localparam logic [6:0]  OP_V_ARITH = 7'h57;
    localparam logic [6:0]  OP_V_LOAD  = 7'h07;
    localparam logic [6:0]  OP_V_STORE = 7'h27;
    localparam logic [2:0]  F3_CFG     = 3'b111;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_VL, WB} state_t;

    state_t          state_q;
    logic [XLEN-1:0] inst_mem_q [DEPTH];
    logic [XLEN-1:0] rs1_mem_q  [DEPTH];
    logic [XLEN-1:0] rs2_mem_q  [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;
    logic            cfg_pending_q;
    logic [4:0]      cfg_rd_q;
    logic            rd_valid_q;
    logic [4:0]      rd_addr_q;
    logic [XLEN-1:0] rd_data_q;
    logic            illegal_q;

    logic            empty;
    logic            full;
    logic [6:0]      in_opcode;
    logic            in_legal;
    logic            in_cfg;
    logic            accept;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] head_inst;
    logic            head_cfg;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign in_opcode = scalar_inst[6:0];
    assign in_legal  = (in_opcode == OP_V_ARITH) || (in_opcode == OP_V_LOAD) ||
                       (in_opcode == OP_V_STORE);
    assign in_cfg    = (in_opcode == OP_V_ARITH) && (scalar_inst[14:12] == F3_CFG);

    // A pending config blocks accepts so its vl lands before any younger scalar instruction.
    assign scalar_inst_ready = reset && !full && !cfg_pending_q;
    assign accept            = scalar_inst_valid && scalar_inst_ready;
    assign push              = accept && in_legal;

    assign head_inst      = inst_mem_q[rd_ptr_q];
    assign head_cfg       = (head_inst[6:0] == OP_V_ARITH) && (head_inst[14:12] == F3_CFG);
    assign vec_inst_valid = !empty && ((state_q == IDLE) || (state_q == ISSUE));
    assign pop            = vec_inst_valid && vec_inst_ready;
    assign vec_inst       = empty ? '0 : head_inst;
    assign vec_rs1_data   = empty ? '0 : rs1_mem_q[rd_ptr_q];
    assign vec_rs2_data   = empty ? '0 : rs2_mem_q[rd_ptr_q];

    assign scalar_rd_valid = rd_valid_q;
    assign scalar_rd_addr  = rd_addr_q;
    assign scalar_rd_data  = rd_data_q;
    assign illegal_inst    = illegal_q;
    assign busy            = !empty || (state_q != IDLE);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cfg_pending_q <= 1'b0;
            cfg_rd_q      <= '0;
            rd_valid_q    <= 1'b0;
            rd_addr_q     <= '0;
            rd_data_q     <= '0;
            illegal_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                rs1_mem_q[i]  <= '0;
                rs2_mem_q[i]  <= '0;
            end
        end else begin
            count_q    <= count_d;
            illegal_q  <= accept && !in_legal;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;

            if (push) begin
                inst_mem_q[wr_ptr_q] <= scalar_inst;
                rs1_mem_q[wr_ptr_q]  <= scalar_rs1_data;
                rs2_mem_q[wr_ptr_q]  <= scalar_rs2_data;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (accept && in_cfg) begin
                cfg_pending_q <= 1'b1;
            end

            case (state_q)
                IDLE, ISSUE: begin
                    if (pop && head_cfg) begin
                        cfg_rd_q <= head_inst[11:7];
                        state_q  <= WAIT_VL;
                    end else begin
                        state_q <= (count_d != '0) ? ISSUE : IDLE;
                    end
                end
                WAIT_VL: begin
                    if (vec_vl_valid) begin
                        state_q    <= WB;
                        rd_valid_q <= (cfg_rd_q != 5'd0);
                        rd_addr_q  <= cfg_rd_q;
                        rd_data_q  <= vec_vl;
                    end
                end
                WB: begin
                    cfg_pending_q <= 1'b0;
                    state_q       <= (count_d != '0) ? ISSUE : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_inst_issue.sv
// Bench for vec_inst_issue: decode table, hand-written handshake/config/reset sequences and a
// randomized run against a queue-based reference model.
module tb_vec_inst_issue;
    localparam int DEPTH = 4;
    localparam logic [31:0] VLE  = 32'h02056007;
    localparam logic [31:0] CFG5 = 32'h0D0572D7;
    localparam logic [31:0] CFG0 = 32'h0D057057;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        siv = 1'b0;
    logic [31:0] sinst = '0, srs1 = '0, srs2 = '0;
    logic        sready;
    logic        rd_valid;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        ill;
    logic        vvalid;
    logic        vready = 1'b0;
    logic [31:0] vinst, vrs1, vrs2;
    logic        vlv = 1'b0;
    logic [31:0] vl = '0;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vec_inst_issue #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .scalar_inst_valid(siv), .scalar_inst(sinst),
        .scalar_rs1_data(srs1), .scalar_rs2_data(srs2),
        .scalar_inst_ready(sready),
        .scalar_rd_valid(rd_valid), .scalar_rd_addr(rd_addr), .scalar_rd_data(rd_data),
        .illegal_inst(ill),
        .vec_inst_valid(vvalid), .vec_inst_ready(vready),
        .vec_inst(vinst), .vec_rs1_data(vrs1), .vec_rs2_data(vrs2),
        .vec_vl_valid(vlv), .vec_vl(vl),
        .busy(busy)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; siv = 1'b0; sinst = '0; srs1 = '0; srs2 = '0;
        vready = 1'b0; vlv = 1'b0; vl = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_ready"}, sready, 1'b0);
        chk1({tag, "_vvalid"}, vvalid, 1'b0);
        chk32({tag, "_vinst"}, vinst, 32'd0);
        chk1({tag, "_rdvalid"}, rd_valid, 1'b0);
        chk32({tag, "_rddata"}, rd_data, 32'd0);
        chk1({tag, "_ill"}, ill, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
    endtask

    typedef struct {
        logic [31:0] inst;
        bit          exp_push;
        bit          exp_ill;
        bit          exp_ready;
    } vec_t;
    vec_t tbl[8];

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } ent_t;

    ent_t        mq[$];
    ent_t        m_head, m_new;
    bit          m_cfg_pend, m_wait, m_wb, m_ill;
    bit          e_ready, e_vv, m_acc, m_pop, was_wait, was_wb;
    logic [4:0]  m_rd;
    logic [31:0] m_vl;

    function automatic bit is_legal(input logic [31:0] w);
        return (w[6:0] == 7'h57) || (w[6:0] == 7'h07) || (w[6:0] == 7'h27);
    endfunction

    function automatic bit is_cfg(input logic [31:0] w);
        return (w[6:0] == 7'h57) && (w[14:12] == 3'b111);
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k <= 2) begin
            w[6:0] = 7'h57;
        end else if (k == 3) begin
            w[6:0] = 7'h57;
            w[14:12] = 3'b111;
            if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
        end else if (k <= 5) begin
            w[6:0] = 7'h07;
        end else if (k <= 7) begin
            w[6:0] = 7'h27;
        end else if (k == 8) begin
            w[6:0] = 7'h33;
        end
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1ms, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        int pushed;

        tbl[0] = '{VLE,          1'b1, 1'b0, 1'b1};
        tbl[1] = '{32'h02056027, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{32'h00000057, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{32'h00006057, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{CFG5,         1'b1, 1'b0, 1'b0};
        tbl[5] = '{32'h00000033, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{32'h00007033, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{32'h0000707F, 1'b0, 1'b1, 1'b1};

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("rst");

        // decode / accept table
        for (int i = 0; i < 8; i++) begin
            do_reset();
            siv = 1'b1; sinst = tbl[i].inst;
            srs1 = 32'hA0 + 32'(i); srs2 = 32'hB0 + 32'(i);
            tick();
            siv = 1'b0;
            chk1($sformatf("tbl%0d_ill", i), ill, tbl[i].exp_ill);
            chk1($sformatf("tbl%0d_vvalid", i), vvalid, tbl[i].exp_push);
            chk32($sformatf("tbl%0d_vinst", i), vinst, tbl[i].exp_push ? tbl[i].inst : 32'd0);
            chk32($sformatf("tbl%0d_vrs1", i), vrs1, tbl[i].exp_push ? 32'hA0 + 32'(i) : 32'd0);
            chk1($sformatf("tbl%0d_ready", i), sready, tbl[i].exp_ready);
            chk1($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_push);
            tick();
            chk1($sformatf("tbl%0d_ill_once", i), ill, 1'b0);
            chk1($sformatf("tbl%0d_vvalid_hold", i), vvalid, tbl[i].exp_push);
        end

        // four loads with the vector side stalled, then drained in order
        do_reset();
        siv = 1'b1; sinst = VLE; srs1 = 32'h1000;
        for (int i = 0; i < 4; i++) begin
            srs2 = 32'(i);
            chk1($sformatf("t1_ready%0d", i), sready, 1'b1);
            tick();
        end
        siv = 1'b0;
        chk1("t1_full_ready", sready, 1'b0);
        tick();
        chk1("t1_hold_valid", vvalid, 1'b1);
        chk32("t1_hold_rs2", vrs2, 32'd0);
        vready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk1($sformatf("t1_pop_valid%0d", k), vvalid, 1'b1);
            chk32($sformatf("t1_pop_rs2_%0d", k), vrs2, 32'(k));
            chk32($sformatf("t1_pop_rs1_%0d", k), vrs1, 32'h1000);
            tick();
        end
        vready = 1'b0;
        chk1("t1_drained_valid", vvalid, 1'b0);
        chk1("t1_drained_busy", busy, 1'b0);
        chk1("t1_drained_ready", sready, 1'b1);

        // vsetvli x5 and vsetvli x0
        for (int r = 0; r < 2; r++) begin
            do_reset();
            siv = 1'b1; sinst = (r == 0) ? CFG5 : CFG0; srs1 = 32'd10; vready = 1'b1;
            tick();
            siv = 1'b0;
            chk1($sformatf("t2_%0d_ready_cfg", r), sready, 1'b0);
            chk1($sformatf("t2_%0d_valid", r), vvalid, 1'b1);
            tick();
            siv = 1'b1; sinst = VLE;
            for (int c = 0; c < 3; c++) begin
                chk1($sformatf("t2_%0d_wait_valid%0d", r, c), vvalid, 1'b0);
                chk1($sformatf("t2_%0d_wait_rdv%0d", r, c), rd_valid, 1'b0);
                chk1($sformatf("t2_%0d_wait_busy%0d", r, c), busy, 1'b1);
                tick();
            end
            siv = 1'b0;
            vlv = 1'b1; vl = 32'd8;
            tick();
            vlv = 1'b0; vl = '0;
            chk1($sformatf("t2_%0d_wb_valid", r), rd_valid, (r == 0) ? 1'b1 : 1'b0);
            chk32($sformatf("t2_%0d_wb_addr", r), 32'(rd_addr), (r == 0) ? 32'd5 : 32'd0);
            chk32($sformatf("t2_%0d_wb_data", r), rd_data, 32'd8);
            chk1($sformatf("t2_%0d_wb_ready", r), sready, 1'b0);
            tick();
            chk1($sformatf("t2_%0d_post_rdv", r), rd_valid, 1'b0);
            chk32($sformatf("t2_%0d_post_data", r), rd_data, 32'd0);
            chk1($sformatf("t2_%0d_post_ready", r), sready, 1'b1);
            chk1($sformatf("t2_%0d_post_busy", r), busy, 1'b0);
            chk1($sformatf("t2_%0d_post_valid", r), vvalid, 1'b0);
        end

        // simultaneous push+pop at three entries, then fill to full
        do_reset();
        siv = 1'b1; sinst = VLE;
        for (int i = 0; i < 3; i++) begin
            srs2 = 32'(i);
            tick();
        end
        srs2 = 32'd3; vready = 1'b1;
        tick();
        chk1("t5_pp_ready", sready, 1'b1);
        chk32("t5_pp_head", vrs2, 32'd1);
        vready = 1'b0; srs2 = 32'd4;
        tick();
        siv = 1'b0;
        chk1("t5_full_ready", sready, 1'b0);
        vready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk32($sformatf("t5_order%0d", k), vrs2, 32'(k));
            tick();
        end
        vready = 1'b0;
        chk1("t5_empty", vvalid, 1'b0);

        // ten pushes streamed through the wrapping pointers
        nxt = 0;
        pushed = 0;
        for (int c = 0; c < 60 && nxt < 10; c++) begin
            vready = 1'($urandom_range(0, 1));
            siv = (pushed < 10);
            srs2 = 32'd100 + 32'(pushed);
            if (vvalid && vready) begin
                chk32($sformatf("t5_wrap%0d", nxt), vrs2, 32'd100 + 32'(nxt));
                nxt++;
            end
            if (siv && sready) pushed++;
            tick();
        end
        siv = 1'b0; vready = 1'b0;
        chk32("t5_wrap_count", 32'(nxt), 32'd10);

        // reset while waiting for vl
        do_reset();
        siv = 1'b1; sinst = VLE;
        tick();
        tick();
        sinst = CFG5;
        tick();
        siv = 1'b0;
        chk1("t6_queued_ready", sready, 1'b0);
        vready = 1'b1;
        tick();
        tick();
        tick();
        vready = 1'b0;
        chk1("t6_wait_valid", vvalid, 1'b0);
        chk1("t6_wait_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        @(negedge clk);
        reset = 1'b1;
        vlv = 1'b1; vl = 32'd9;
        tick();
        tick();
        vlv = 1'b0; vl = '0;
        chk1("t6_vl_ignored", rd_valid, 1'b0);
        chk1("t6_busy", busy, 1'b0);
        chk1("t6_ready", sready, 1'b1);

        // randomized run against the queue model
        do_reset();
        mq.delete();
        m_cfg_pend = 1'b0; m_wait = 1'b0; m_wb = 1'b0; m_ill = 1'b0;
        m_rd = '0; m_vl = '0;
        for (int c = 0; c < 3000 && bad < 40; c++) begin
            e_ready = (mq.size() < DEPTH) && !m_cfg_pend;
            e_vv    = (mq.size() > 0) && !m_wait && !m_wb;
            m_head  = (mq.size() > 0) ? mq[0] : '0;
            chk1("rnd_ready", sready, e_ready);
            chk1("rnd_vvalid", vvalid, e_vv);
            chk32("rnd_vinst", vinst, m_head.inst);
            chk32("rnd_vrs1", vrs1, m_head.rs1);
            chk32("rnd_vrs2", vrs2, m_head.rs2);
            chk1("rnd_rdvalid", rd_valid, m_wb && (m_rd != 5'd0));
            chk32("rnd_rdaddr", 32'(rd_addr), m_wb ? 32'(m_rd) : 32'd0);
            chk32("rnd_rddata", rd_data, m_wb ? m_vl : 32'd0);
            chk1("rnd_ill", ill, m_ill);
            chk1("rnd_busy", busy, (mq.size() != 0) || m_wait || m_wb);

            siv    = ($urandom_range(0, 9) < 6);
            sinst  = rand_inst();
            srs1   = $urandom;
            srs2   = $urandom;
            vready = ($urandom_range(0, 9) < 6);
            vlv    = ($urandom_range(0, 3) == 0);
            vl     = $urandom_range(0, 256);

            m_acc    = siv && e_ready;
            m_pop    = e_vv && vready;
            was_wait = m_wait;
            was_wb   = m_wb;
            m_ill    = m_acc && !is_legal(sinst);
            if (m_pop) begin
                m_head = mq.pop_front();
                if (is_cfg(m_head.inst)) begin
                    m_wait = 1'b1;
                    m_rd   = m_head.inst[11:7];
                end
            end
            if (m_acc && is_legal(sinst)) begin
                m_new.inst = sinst; m_new.rs1 = srs1; m_new.rs2 = srs2;
                mq.push_back(m_new);
            end
            m_wb = 1'b0;
            if (was_wait && vlv) begin
                m_wait = 1'b0;
                m_wb   = 1'b1;
                m_vl   = vl;
            end
            if (was_wb) m_cfg_pend = 1'b0;
            if (m_acc && is_cfg(sinst)) m_cfg_pend = 1'b1;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
